// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one combinational ALU between two requesters.
//
// Two valid/ready request ports are arbitrated round-robin. The winner's
// operands and function code are registered and drive the ALU. After a fixed,
// per-operation latency the ALU result is captured. It is then returned on a
// valid/ready response port, tagged with the requester id.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req{0,1}_valid/_ready     request handshake (ready is combinational)
//   req{0,1}_a/_b/_f          request operands and 3-bit function code
//   alu_a, alu_b, alu_f       registered ALU inputs
//   alu_r                     ALU result (combinational from alu_a/b/f)
//   rsp_valid/_ready          response handshake
//   rsp_id, rsp_r             issuing requester and captured result
module alu_share_ctrl #(
  parameter int unsigned W       = 32,
  parameter int unsigned ADD_LAT = 1,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned CW      = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [2:0]   req0_f,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [2:0]   req1_f,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_f,
  input  logic [W-1:0] alu_r,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_r
);

  // The counter is loaded with LAT-1 so that EXEC lasts exactly LAT cycles.
  localparam logic [CW-1:0] AddCnt = CW'(ADD_LAT - 1);
  localparam logic [CW-1:0] MulCnt = CW'(MUL_LAT - 1);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_grant_q, last_grant_d;
  logic [W-1:0]  alu_a_q, alu_a_d;
  logic [W-1:0]  alu_b_q, alu_b_d;
  logic [2:0]    alu_f_q, alu_f_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_id_q, rsp_id_d;
  logic [W-1:0]  rsp_r_q, rsp_r_d;

  logic          grant;
  logic          accept;
  logic [2:0]    sel_f;

  // A lone requester always wins. When both requesters are valid, the one
  // not granted last time wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state_q == StIdle) && req0_valid && !grant;
  assign req1_ready = (state_q == StIdle) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;
  assign sel_f      = grant ? req1_f : req0_f;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_f_d      = alu_f_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_r_d      = rsp_r_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          alu_a_d      = grant ? req1_a : req0_a;
          alu_b_d      = grant ? req1_b : req0_b;
          alu_f_d      = sel_f;
          rsp_id_d     = grant;
          last_grant_d = grant;
          cnt_d        = sel_f[2] ? MulCnt : AddCnt;
          state_d      = StExec;
        end
      end
      StExec: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          rsp_r_d     = alu_r;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_f_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_r_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_f_q      <= alu_f_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_r_q      <= rsp_r_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_f     = alu_f_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_r     = rsp_r_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Testbench for alu_share_ctrl: directed vectors with hand-computed results,
// expected responses queued at issue time and checked by a response monitor.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic [2:0]  req0_f;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [2:0]  req1_f;
  logic [31:0] alu_a, alu_b, alu_r;
  logic [2:0]  alu_f;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_r;

  int ntests = 0;
  int nfail  = 0;
  logic [32:0] exp_q[$];  // {id, result}

  always #5 clk = ~clk;

  alu_share_ctrl #(.W(32), .ADD_LAT(1), .MUL_LAT(3), .CW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_f     (req0_f),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_f     (req1_f),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_f      (alu_f),
    .alu_r      (alu_r),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_r      (rsp_r)
  );

  // Reference ALU: add, inc, sub, dec, 16x16 multiply.
  always_comb begin
    case (alu_f)
      3'b000:  alu_r = alu_a + alu_b;
      3'b001:  alu_r = alu_a + 32'd1;
      3'b010:  alu_r = alu_a - alu_b;
      3'b011:  alu_r = alu_a - 32'd1;
      default: alu_r = alu_a[15:0] * alu_b[15:0];
    endcase
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  // Response monitor: each handshake pops one expected entry.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("rsp_id", {31'd0, rsp_id}, {31'd0, e[32]});
        check("rsp_r", rsp_r, e[31:0]);
      end
    end
  end

  task automatic drive(input bit id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f, input logic v);
    if (id) begin
      req1_a = a; req1_b = b; req1_f = f; req1_valid = v;
    end else begin
      req0_a = a; req0_b = b; req0_f = f; req0_valid = v;
    end
  endtask

  // Present a request, wait (bounded) for its ready, queue the expected
  // response and return 1 time unit after the accept edge with valid dropped.
  task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f, input logic [31:0] r, input bit push);
    bit ok;
    ok = 1'b0;
    drive(id, a, b, f, 1'b1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept", {31'd0, ok}, 32'd1);
    if (push) exp_q.push_back({id, r});
    @(posedge clk);
    #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int g, cyc, last_cyc;
    bit seen;

    rst = 1'b1;
    rsp_ready = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0);
    drive(1'b1, '0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    check("reset_alu_a", alu_a, 32'd0);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_r", rsp_r, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: add 5+7 on requester 0, rsp one cycle after EXEC.
    issue(1'b0, 32'd5, 32'd7, 3'b000, 32'd12, 1'b1);
    @(negedge clk);
    check("t1_alu_a", alu_a, 32'd5);
    check("t1_alu_b", alu_b, 32'd7);
    check("t1_alu_f", {29'd0, alu_f}, 32'd0);
    check("t1_exec_no_rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    drain();

    // 2: multiply 3*4 on requester 1, exactly 3 EXEC cycles.
    issue(1'b1, 32'd3, 32'd4, 3'b100, 32'd12, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_exec_no_rsp", {31'd0, rsp_valid}, 32'd0);
      check("t2_alu_a", alu_a, 32'd3);
      check("t2_alu_b", alu_b, 32'd4);
      check("t2_alu_f", {29'd0, alu_f}, 32'd4);
    end
    @(negedge clk);
    check("t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    drain();

    // 3: both valid continuously; grants alternate starting with 0.
    drive(1'b0, 32'd9, 32'd0, 3'b001, 1'b1);
    drive(1'b1, 32'd9, 32'd0, 3'b011, 1'b1);
    g = 0; cyc = 0; last_cyc = 0;
    while (g < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (req0_ready || req1_ready) begin
        check("t3_one_ready", {31'd0, req0_ready && req1_ready}, 32'd0);
        check("t3_grant", {31'd0, req1_ready}, g % 2);
        exp_q.push_back((g % 2) != 0 ? {1'b1, 32'd8} : {1'b0, 32'd10});
        if (g > 0) check("t3_spacing", cyc - last_cyc, 32'd3);
        last_cyc = cyc;
        g++;
      end
    end
    check("t3_grants", g, 32'd4);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();

    // 4: back-pressure with both requesters asking during RESP.
    rsp_ready = 1'b0;
    issue(1'b0, 32'd20, 32'd6, 3'b010, 32'd14, 1'b1);
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    drive(1'b0, 32'd77, 32'd1, 3'b000, 1'b1);
    drive(1'b1, 32'd88, 32'd1, 3'b000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("t4_hold_r", rsp_r, 32'd14);
      check("t4_hold_id", {31'd0, rsp_id}, 32'd0);
      check("t4_no_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t4_single_hs", {31'd0, rsp_valid}, 32'd0);
    drain();

    // 5: reset in the 2nd EXEC cycle of a multiply aborts it.
    issue(1'b1, 32'd7, 32'd6, 3'b100, 32'd42, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_alu_a", alu_a, 32'd0);
    check("t5_rst_alu_b", alu_b, 32'd0);
    check("t5_rst_alu_f", {29'd0, alu_f}, 32'd0);
    check("t5_rst_rsp_r", rsp_r, 32'd0);
    check("t5_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("t5_no_rsp_after_rst", {31'd0, seen}, 32'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 32'd1, 32'd2, 3'b000, 1'b1);
    drive(1'b1, 32'd3, 32'd4, 3'b000, 1'b1);
    @(negedge clk);
    check("t5_first_grant", {30'd0, req0_ready, req1_ready}, 32'd2);
    exp_q.push_back({1'b0, 32'd3});
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();

    // 6: lone requester 1 wins back-to-back; code 111 passes through.
    seen = 1'b0;
    issue(1'b1, 32'd100, 32'd23, 3'b000, 32'd123, 1'b1);
    if (req0_ready) seen = 1'b1;
    issue(1'b1, 32'd50, 32'd8, 3'b010, 32'd42, 1'b1);
    if (req0_ready) seen = 1'b1;
    issue(1'b1, 32'h0000_FFFF, 32'h0000_FFFF, 3'b111, 32'hFFFE_0001, 1'b1);
    @(negedge clk);
    check("t6_alu_f", {29'd0, alu_f}, 32'd7);
    check("t6_no_req0", {31'd0, seen || req0_ready}, 32'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Two-requester scheduler sharing one 32-bit ALU (add, increment, subtract, decrement, 16x16 multiply; 3-bit function code).
- Arbitrates round-robin between two valid/ready request ports and drives the ALU operand and function inputs from registered copies.
- Waits a fixed, per-operation latency, then captures the ALU result and returns it on one valid/ready response port tagged with the requester id.

Parameters:
- W, 32, operand/result width; matches the ALU.
- ADD_LAT, 1, EXEC cycles for F[2]=0 operations (add/inc/sub/dec); must be >=1.
- MUL_LAT, 3, EXEC cycles for F[2]=1 operations (multiply); must be >=1.
- CW, 4, latency counter width; 2^CW must exceed max(ADD_LAT, MUL_LAT).

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  controller accepts requester 0 this cycle.
- req0_a  in  W  requester 0 operand A.
- req0_b  in  W  requester 0 operand B.
- req0_f  in  3  requester 0 function code.
- req1_valid, req1_ready, req1_a, req1_b, req1_f: same as the requester 0 signals, for requester 1.
- alu_a  out  W  ALU operand A (registered).
- alu_b  out  W  ALU operand B (registered).
- alu_f  out  3  ALU function (registered).
- alu_r  in  W  ALU result (combinational from alu_a/alu_b/alu_f).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_id  out  1  requester that issued the result.
- rsp_r  out  W  captured result.

Behaviour:
- Clock and reset are fixed: one clock, clk; rst is asynchronous and active-high.
- Reset values: state=IDLE, alu_a=alu_b=0, alu_f=0, rsp_valid=0, rsp_id=0, rsp_r=0, cnt=0, last_grant=1, so requester 0 wins first.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - grant = 1 if only req1_valid is high.
  - grant = 0 if only req0_valid is high.
  - If both are high, grant = ~last_grant.
  - reqX_ready = (state==IDLE) && reqX_valid && (grant==X); this is combinational, and at most one ready is high.
  - Ready is never high outside IDLE.
- Accept, in a cycle where reqX_valid && reqX_ready:
  - Latch a/b/f into alu_a/alu_b/alu_f.
  - Latch rsp_id=X and last_grant=X.
  - Load cnt = (f[2] ? MUL_LAT : ADD_LAT) - 1.
  - Go to EXEC.
- EXEC:
  - alu_a/alu_b/alu_f are held constant.
  - If cnt != 0, decrement cnt.
  - If cnt == 0, capture rsp_r <= alu_r, set rsp_valid=1, go to RESP.
  - EXEC therefore lasts exactly LAT cycles.
- Latency: accept at edge T gives rsp_valid high after edge T+LAT, e.g. add = 1 EXEC cycle and rsp_valid in the 2nd cycle after the accept cycle.
- RESP:
  - rsp_valid, rsp_id and rsp_r are held stable until rsp_valid && rsp_ready.
  - On that edge: rsp_valid=0, go to IDLE.
  - No new request is accepted in the same cycle; the next accept is earliest one cycle later.
- Minimum issue interval: LAT+2 cycles.
- Operands: alu_a/b/f keep the last operation's values in IDLE; they do not follow the request inputs.
- Function codes are passed through unmodified.
- Requests are not checked: codes 1xx all use MUL_LAT; codes 110/111 are passed to the ALU as-is.
- rsp_r is exactly W bits from alu_r; no truncation or extension in this block.
- Requester inputs may change freely while reqX_ready is low; they are only sampled on the accept edge.
- rsp_ready while rsp_valid is low is ignored.
- A requester dropping valid while not granted is legal.
- Fairness: with both valid continuously, grants alternate 0,1,0,1...
- A lone requester is granted back-to-back regardless of last_grant.
- Reset mid-operation (rst high in EXEC or RESP) aborts immediately. The in-flight result is discarded, all outputs return to reset values, and no response is emitted after reset.

Test Plan:
- Reset then req0 f=000 a=5 b=7 with ADD_LAT=1 -> req0_ready high in the request cycle; alu_a=5, alu_b=7, alu_f=000 next cycle; rsp_valid one cycle later with rsp_r=12, rsp_id=0.
- req1 f=100 a=0x0000_0003 b=0x0000_0004 with MUL_LAT=3 -> exactly 3 EXEC cycles; rsp_valid with rsp_r=12, rsp_id=1; alu inputs stable for all 3 cycles.
- Both requesters valid every cycle (req0 f=001 a=9, req1 f=011 a=9) with rsp_ready tied high -> grants alternate 0,1,0,1; responses 10,8,10,8; ids 0,1,0,1; issue spacing 3 cycles.
- Back-pressure: hold rsp_ready=0 for 5 cycles after rsp_valid (f=010 a=20 b=6) -> rsp_r=14 and rsp_id stable for all 5 cycles; both readys low throughout; single handshake when rsp_ready rises.
- Reset asserted in the 2nd EXEC cycle of a multiply (MUL_LAT=3) -> all outputs zero asynchronously; no rsp_valid after rst falls; the next request is granted to requester 0.
- Lone req1 valid for 3 operations with rsp_ready high -> all three granted to requester 1; req0_ready never high.
